// File: rtl/accel_cfg_glb_port.sv
// accel_cfg_glb_port: host-facing register file, layer launch sequencer and
// owner of the single GLB port shared by the host loader and the controller.
// Base addresses are computed over three registered stages before the
// controller is started. The state register is visible on state_dbg.
// Optional build macro GLB_RDATA_REG_EN: registers host_r_data (1-cycle latency).
module accel_cfg_glb_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int BIAS_B = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_wen,
    input  logic [2:0]        cfg_wsel,
    input  logic [31:0]       cfg_wdata,
    input  logic [2:0]        cfg_rsel,
    output logic [31:0]       cfg_rdata,
    output logic [31:0]       op_config,
    output logic [31:0]       mapping_param,
    output logic [31:0]       shape_param1,
    output logic [31:0]       shape_param2,
    output logic              bias_ipsum_sel,
    output logic [ADDR_W-1:0] filter_base,
    output logic [ADDR_W-1:0] bias_base,
    output logic [ADDR_W-1:0] opsum_base,
    output logic              ctrl_start,
    input  logic              ctrl_done,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_dbg,
    input  logic [3:0]        host_we,
    input  logic [ADDR_W-1:0] host_w_addr,
    input  logic [DATA_W-1:0] host_w_data,
    input  logic              host_re,
    input  logic [ADDR_W-1:0] host_r_addr,
    output logic [DATA_W-1:0] host_r_data,
    input  logic [3:0]        ctrl_we,
    input  logic [ADDR_W-1:0] ctrl_w_addr,
    input  logic [DATA_W-1:0] ctrl_w_data,
    input  logic              ctrl_re,
    input  logic [ADDR_W-1:0] ctrl_r_addr,
    output logic [3:0]        glb_we,
    output logic [ADDR_W-1:0] glb_w_addr,
    output logic [DATA_W-1:0] glb_w_data,
    output logic              glb_re,
    output logic [ADDR_W-1:0] glb_r_addr,
    input  logic [DATA_W-1:0] glb_r_data
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR0  = 3'd1;
    localparam logic [2:0] S_ADDR1  = 3'd2;
    localparam logic [2:0] S_ADDR2  = 3'd3;
    localparam logic [2:0] S_LAUNCH = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    // Controller handshake: ctrl_start is a one-cycle pulse issued once per
    // launch; ctrl_done is a one-cycle pulse that is only honoured in RUN.
    // Anything else on ctrl_done is a protocol violation and raises err.

    logic [2:0] state, state_nxt;

    logic cfg_wr_ok, cfg_wr_drop, launch, status_clr, err_set;

    assign cfg_wr_ok   = cfg_wen && (cfg_wsel <= 3'd4) && !busy;
    assign cfg_wr_drop = cfg_wen && (cfg_wsel <= 3'd4) && busy;
    assign launch      = cfg_wen && (cfg_wsel == 3'd4) && cfg_wdata[0] && (state == S_IDLE);
    assign status_clr  = cfg_wen && (cfg_wsel == 3'd5);
    assign err_set     = cfg_wr_drop
                       || (ctrl_done && (state != S_RUN))
                       || (busy && ((host_we != 4'b0) || host_re));

    assign state_dbg = state;

    // Layer fields widened to the address width; all arithmetic wraps at 2^ADDR_W.
    logic [4:0]        e_f;
    logic [ADDR_W-1:0] t_w, r_w, q_w, p_w, em1_w, rr_w, s_w, u_w, w_w;
    logic [ADDR_W-1:0] filter_calc, bias_calc, opsum_calc;

    assign e_f   = mapping_param[16:12];
    assign t_w   = ADDR_W'(mapping_param[2:0]);
    assign r_w   = ADDR_W'(mapping_param[5:3]);
    assign q_w   = ADDR_W'(mapping_param[8:6]);
    assign p_w   = ADDR_W'(mapping_param[11:9]);
    assign em1_w = (e_f == 5'd0) ? '0 : ADDR_W'(e_f) - ADDR_W'(1);
    assign rr_w  = ADDR_W'(shape_param1[23:22]);
    assign s_w   = ADDR_W'(shape_param1[21:20]);
    assign u_w   = ADDR_W'(shape_param1[25:24]);
    assign w_w   = ADDR_W'(shape_param2[15:8]);

    assign filter_calc = q_w * r_w * (u_w * em1_w + rr_w) * w_w;
    assign bias_calc   = filter_base + p_w * t_w * q_w * r_w * rr_w * s_w;
    assign opsum_calc  = bias_base + p_w * t_w * ADDR_W'(BIAS_B);

    // Next-state logic for the launch sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (launch) state_nxt = S_ADDR0;
            S_ADDR0:  state_nxt = S_ADDR1;
            S_ADDR1:  state_nxt = S_ADDR2;
            S_ADDR2:  state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_RUN;
            S_RUN:    if (ctrl_done) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register and the registered start pulse (issued on leaving LAUNCH).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ctrl_start <= 1'b0;
        end else begin
            state      <= state_nxt;
            ctrl_start <= (state == S_LAUNCH);
        end
    end

    // Host-writable configuration; writes are frozen while a layer is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mapping_param  <= '0;
            shape_param1   <= '0;
            shape_param2   <= '0;
            bias_ipsum_sel <= 1'b0;
            op_config      <= '0;
        end else if (cfg_wr_ok) begin
            case (cfg_wsel)
                3'd0:    mapping_param  <= cfg_wdata;
                3'd1:    shape_param1   <= cfg_wdata;
                3'd2:    shape_param2   <= cfg_wdata;
                3'd3:    bias_ipsum_sel <= cfg_wdata[0];
                3'd4:    op_config      <= cfg_wdata;
                default: ;
            endcase
        end
    end

    // Base-address pipe: each region base builds on the one computed before it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filter_base <= '0;
            bias_base   <= '0;
            opsum_base  <= '0;
        end else begin
            if (state == S_ADDR0) filter_base <= filter_calc;
            if (state == S_ADDR1) bias_base   <= bias_calc;
            if (state == S_ADDR2) opsum_base  <= opsum_calc;
        end
    end

    // Status flags: busy spans launch to DONE; done set beats clear; a new error beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (launch)
                busy <= 1'b1;
            else if ((state == S_RUN) && ctrl_done)
                busy <= 1'b0;

            if ((state == S_RUN) && ctrl_done)
                done <= 1'b1;
            else if (launch || status_clr)
                done <= 1'b0;

            if (err_set)
                err <= 1'b1;
            else if (status_clr)
                err <= 1'b0;
        end
    end

    // Register readback; status packs {err, done, busy} in the low bits.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_rsel)
            3'd0:    cfg_rdata = mapping_param;
            3'd1:    cfg_rdata = shape_param1;
            3'd2:    cfg_rdata = shape_param2;
            3'd3:    cfg_rdata = {31'b0, bias_ipsum_sel};
            3'd4:    cfg_rdata = op_config;
            3'd6:    cfg_rdata = {29'b0, err, done, busy};
            default: cfg_rdata = '0;
        endcase
    end

    // GLB port belongs to the controller while busy, to the host otherwise.
    assign glb_we     = busy ? ctrl_we     : host_we;
    assign glb_w_addr = busy ? ctrl_w_addr : host_w_addr;
    assign glb_w_data = busy ? ctrl_w_data : host_w_data;
    assign glb_re     = busy ? ctrl_re     : host_re;
    assign glb_r_addr = busy ? ctrl_r_addr : host_r_addr;

`ifdef GLB_RDATA_REG_EN
    // Host read data retimed by one cycle; blanked while the controller owns the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            host_r_data <= '0;
        else
            host_r_data <= busy ? '0 : glb_r_data;
    end
`else
    assign host_r_data = busy ? '0 : glb_r_data;
`endif

endmodule

// File: tb/tb_accel_cfg_glb_port.sv
// Bench for accel_cfg_glb_port: launch sequencing, base-address math,
// GLB ownership, lock-out, status flags, readback and async reset.
module tb_accel_cfg_glb_port;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  logic              clk;
  logic              rst_n;
  logic              cfg_wen;
  logic [2:0]        cfg_wsel;
  logic [31:0]       cfg_wdata;
  logic [2:0]        cfg_rsel;
  logic [31:0]       cfg_rdata;
  logic [31:0]       op_config, mapping_param, shape_param1, shape_param2;
  logic              bias_ipsum_sel;
  logic [ADDR_W-1:0] filter_base, bias_base, opsum_base;
  logic              ctrl_start, ctrl_done, busy, done, err;
  logic [2:0]        state_dbg;
  logic [3:0]        host_we;
  logic [ADDR_W-1:0] host_w_addr, host_r_addr;
  logic [DATA_W-1:0] host_w_data, host_r_data;
  logic              host_re;
  logic [3:0]        ctrl_we;
  logic [ADDR_W-1:0] ctrl_w_addr, ctrl_r_addr;
  logic [DATA_W-1:0] ctrl_w_data;
  logic              ctrl_re;
  logic [3:0]        glb_we;
  logic [ADDR_W-1:0] glb_w_addr, glb_r_addr;
  logic [DATA_W-1:0] glb_w_data, glb_r_data;
  logic              glb_re;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];

  accel_cfg_glb_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BIAS_B(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wen(cfg_wen), .cfg_wsel(cfg_wsel), .cfg_wdata(cfg_wdata),
    .cfg_rsel(cfg_rsel), .cfg_rdata(cfg_rdata),
    .op_config(op_config), .mapping_param(mapping_param),
    .shape_param1(shape_param1), .shape_param2(shape_param2),
    .bias_ipsum_sel(bias_ipsum_sel),
    .filter_base(filter_base), .bias_base(bias_base), .opsum_base(opsum_base),
    .ctrl_start(ctrl_start), .ctrl_done(ctrl_done),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg),
    .host_we(host_we), .host_w_addr(host_w_addr), .host_w_data(host_w_data),
    .host_re(host_re), .host_r_addr(host_r_addr), .host_r_data(host_r_data),
    .ctrl_we(ctrl_we), .ctrl_w_addr(ctrl_w_addr), .ctrl_w_data(ctrl_w_data),
    .ctrl_re(ctrl_re), .ctrl_r_addr(ctrl_r_addr),
    .glb_we(glb_we), .glb_w_addr(glb_w_addr), .glb_w_data(glb_w_data),
    .glb_re(glb_re), .glb_r_addr(glb_r_addr), .glb_r_data(glb_r_data)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pop the next expected value and compare it with what the DUT shows now.
  task automatic sb_pop(input string tag, input logic [31:0] got);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, got, e);
    end
  endtask

  // Driver: called just after a rising edge; the write lands on the next edge.
  task automatic cfg_write(input logic [2:0] sel, input logic [31:0] d);
    cfg_wsel  = sel;
    cfg_wdata = d;
    cfg_wen   = 1'b1;
    @(posedge clk); #1;
    cfg_wen   = 1'b0;
  endtask

  task automatic load_layer(input logic [31:0] m, input logic [31:0] s1, input logic [31:0] s2);
    cfg_write(3'd0, m);
    cfg_write(3'd1, s1);
    cfg_write(3'd2, s2);
  endtask

  // Start a layer, expect the three bases, a 4-cycle start latency and a one-cycle pulse.
  task automatic launch_and_check(input logic [31:0] ef, input logic [31:0] eb, input logic [31:0] eo);
    int cyc;
    logic seen;
    exp_q.push_back(ef);
    exp_q.push_back(eb);
    exp_q.push_back(eo);
    cfg_write(3'd4, 32'h1);
    check_eq("busy_at_launch", 32'(busy), 32'd1);
    check_eq("op_config_launch", op_config, 32'h1);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (ctrl_start) seen = 1'b1;
    end
    check_eq("start_latency", 32'(cyc), 32'd4);
    sb_pop("filter_base", filter_base);
    sb_pop("bias_base", bias_base);
    sb_pop("opsum_base", opsum_base);
    @(posedge clk); #1;
    check_eq("start_single", 32'(ctrl_start), 32'd0);
    check_eq("state_run", 32'(state_dbg), 32'(ST_RUN));
  endtask

  initial begin
    int starts;
    logic [31:0] a;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    cfg_wen = 1'b0; cfg_wsel = '0; cfg_wdata = '0; cfg_rsel = '0;
    ctrl_done = 1'b0;
    host_we = '0; host_w_addr = '0; host_w_data = '0; host_re = 1'b0; host_r_addr = '0;
    ctrl_we = '0; ctrl_w_addr = '0; ctrl_w_data = '0; ctrl_re = 1'b0; ctrl_r_addr = '0;
    glb_r_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_start", 32'(ctrl_start), 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check_eq("rst_map", mapping_param, 32'd0);
    check_eq("rst_fbase", filter_base, 32'd0);

    // Config and readback: q=2 r=1 e=4 p=2 t=1, R=3 S=3 U=1, W=8
    load_layer(32'h0000_4489, 32'h01F0_0000, 32'h0000_0800);
    cfg_rsel = 3'd0; #1;
    check_eq("rd_map", cfg_rdata, 32'h0000_4489);
    cfg_rsel = 3'd2; #1;
    check_eq("rd_sh2", cfg_rdata, 32'h0000_0800);
    cfg_write(3'd3, 32'h1);
    check_eq("bias_sel", 32'(bias_ipsum_sel), 32'd1);

    // Idle ownership: controller ignored, host drives the port
    ctrl_we = 4'h5; host_we = 4'h0; #1;
    check_eq("idle_ctrl_we_ignored", 32'(glb_we), 32'd0);
    for (int k = 0; k < 4; k++) begin
      a = $urandom_range(0, 32'hFFFF);
      host_we = 4'($urandom_range(1, 15));
      host_w_addr = a;
      exp_q.push_back(a);
      exp_q.push_back(32'(host_we));
      #1;
      sb_pop("idle_glb_w_addr", glb_w_addr);
      sb_pop("idle_glb_we", 32'(glb_we));
    end
    @(posedge clk); #1;
    host_we = '0; ctrl_we = '0;
    check_eq("idle_no_err", 32'(err), 32'd0);

    // Host readback while idle
    glb_r_data = 32'hDEAD_BEEF; host_re = 1'b1; host_r_addr = 32'h40;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    check_eq("idle_glb_re", 32'(glb_re), 32'd1);
    check_eq("idle_glb_r_addr", glb_r_addr, 32'h40);
`ifdef GLB_RDATA_REG_EN
    @(posedge clk); #1;
`endif
    sb_pop("host_r_data", host_r_data);
    @(posedge clk); #1;
    host_re = 1'b0; glb_r_data = '0;

    // Plain op_config update without launch
    cfg_write(3'd4, 32'h10);
    check_eq("op_cfg_plain", op_config, 32'h10);
    @(posedge clk); #1;
    check_eq("plain_no_busy", 32'(busy), 32'd0);
    check_eq("plain_state", 32'(state_dbg), 32'(ST_IDLE));

    // Launch with the example layer
    launch_and_check(32'd96, 32'd132, 32'd140);

    // Lock-out while busy
    a = $urandom_range(0, 32'hFFFF);
    ctrl_w_addr = a;
    exp_q.push_back(a);
    host_we = 4'hF; ctrl_we = 4'h3;
    cfg_wsel = 3'd0; cfg_wdata = 32'hFFFF; cfg_wen = 1'b1;
    #1;
    check_eq("busy_glb_we", 32'(glb_we), 32'd3);
    sb_pop("busy_glb_w_addr", glb_w_addr);
    @(posedge clk); #1;
    cfg_wen = 1'b0; host_we = '0; ctrl_we = '0;
    check_eq("locked_map", mapping_param, 32'h0000_4489);
    check_eq("locked_err", 32'(err), 32'd1);
    glb_r_data = 32'hDEAD_BEEF; host_re = 1'b1;
    @(posedge clk); #1;
    check_eq("busy_host_rdata", host_r_data, 32'd0);
    check_eq("busy_glb_re", 32'(glb_re), 32'd0);
    host_re = 1'b0; glb_r_data = '0;

    // Done pulse
    ctrl_done = 1'b1;
    @(posedge clk); #1;
    ctrl_done = 1'b0;
    check_eq("done_busy", 32'(busy), 32'd0);
    check_eq("done_set", 32'(done), 32'd1);
    check_eq("state_done", 32'(state_dbg), 32'(ST_DONE));
    @(posedge clk); #1;
    check_eq("state_idle", 32'(state_dbg), 32'(ST_IDLE));
    check_eq("done_sticky", 32'(done), 32'd1);
    cfg_write(3'd5, 32'h0);
    check_eq("clr_done", 32'(done), 32'd0);
    check_eq("clr_err", 32'(err), 32'd0);
    cfg_rsel = 3'd6; #1;
    check_eq("status_clear", cfg_rdata, 32'd0);

    // ctrl_done outside RUN is an error
    ctrl_done = 1'b1;
    @(posedge clk); #1;
    ctrl_done = 1'b0;
    check_eq("stray_done_err", 32'(err), 32'd1);
    check_eq("stray_done_flag", 32'(done), 32'd0);

    // e = 0 edge: q=1 r=1 p=1 t=1, R=3 S=1 U=1, W=4
    load_layer(32'h0000_0249, 32'h01D0_0000, 32'h0000_0400);
    launch_and_check(32'd12, 32'd15, 32'd19);

    // Simultaneous done and clear in RUN
    ctrl_done = 1'b1;
    cfg_wsel = 3'd5; cfg_wdata = '0; cfg_wen = 1'b1;
    @(posedge clk); #1;
    ctrl_done = 1'b0; cfg_wen = 1'b0;
    check_eq("sim_done", 32'(done), 32'd1);
    check_eq("sim_err", 32'(err), 32'd0);
    cfg_rsel = 3'd6; #1;
    check_eq("sim_status", cfg_rdata, 32'd2);
    repeat (2) @(posedge clk);
    #1;

    // Async reset mid-RUN
    launch_and_check(32'd12, 32'd15, 32'd19);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_state", 32'(state_dbg), 32'(ST_IDLE));
    check_eq("arst_fbase", filter_base, 32'd0);
    check_eq("arst_map", mapping_param, 32'd0);
    check_eq("arst_start", 32'(ctrl_start), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    starts = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ctrl_start) starts++;
    end
    check_eq("arst_no_start", 32'(starts), 32'd0);
    check_eq("arst_idle", 32'(state_dbg), 32'(ST_IDLE));
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
